mem_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared main-memory port in the multicore design. It takes memory requests from up to `N_REQ` cache controllers, grants one at a time, and drives the single memory interface. It returns read data and a completion pulse to the granted requester and rotates priority after every transaction. A watchdog aborts transactions whose memory response never arrives.

---
 rtl/mem_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared main-memory port.
// Grants one requester at a time, latches its request fields, drives the
// memory interface, and returns a one-cycle done pulse (with err on watchdog
// abort). Priority rotates past the served requester after every transaction.
module mem_bus_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          rw,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      mem_valid,
    output logic                      mem_rw,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Watchdog counts 0 .. TIMEOUT-1, one value per MEM cycle.
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StMem,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [PTR_W-1:0]    idx_q, idx_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                abort_q, abort_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    int unsigned         scan_pos;

    // Round-robin search: first active request at or after ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_pos  = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_pos = 32'(ptr_q) + k;
            if (scan_pos >= N_REQ) begin
                scan_pos = scan_pos - N_REQ;
            end
            if (!win_found && req[PTR_W'(scan_pos)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(scan_pos);
            end
        end
    end

    // Next-state and datapath updates for the IDLE -> MEM -> RESP sequence.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        wd_d        = wd_q;
        abort_d     = abort_q;
        rdata_d     = rdata_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d          = StMem;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    idx_d            = win_idx;
                    wd_d             = '0;
                    abort_d          = 1'b0;
                    // Requester fields are frozen here; later changes are ignored.
                    mem_rw_d         = rw[win_idx];
                    mem_addr_d       = addr[win_idx*ADDR_W +: ADDR_W];
                    mem_wdata_d      = wdata[win_idx*DATA_W +: DATA_W];
                end
            end
            StMem: begin
                if (mem_ready) begin
                    state_d = StResp;
                    rdata_d = mem_rw_q ? '0 : mem_rdata;
                end else if (wd_q == WD_LAST) begin
                    state_d = StResp;
                    abort_d = 1'b1;
                    rdata_d = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
                gnt_d   = '0;
                wd_d    = '0;
                abort_d = 1'b0;
                rdata_d = '0;
                // Served requester drops to lowest priority, aborted or not.
                ptr_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                wd_d    = '0;
                abort_d = 1'b0;
                rdata_d = '0;
            end
        endcase
    end

    // State and datapath registers; reset drops any transaction silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            idx_q       <= '0;
            ptr_q       <= '0;
            wd_q        <= '0;
            abort_q     <= 1'b0;
            rdata_q     <= '0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            wd_q        <= wd_d;
            abort_q     <= abort_d;
            rdata_q     <= rdata_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = (state_q == StResp) ? gnt_q : '0;
    assign err       = abort_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != StIdle);
    assign mem_valid = (state_q == StMem);
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change and outputs are sampled
// on the falling clock edge; each task starts and ends in IDLE.
module tb_mem_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, rw, gnt, done;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic            err, busy, mem_valid, mem_rw, mem_ready;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .rw       (rw),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .busy     (busy),
        .mem_valid(mem_valid),
        .mem_rw   (mem_rw),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b0; req = '0; rw = '0; addr = '0; wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, done, err, busy, mem_valid, mem_rw} !== '0)
            $display("FAIL reset_ctrl: gnt=%b done=%b err=%b busy=%b mv=%b mrw=%b, want all 0",
                     gnt, done, err, busy, mem_valid, mem_rw);
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, want 0", mem_addr, mem_wdata, rdata);
        end
        if ({gnt, done, err, busy, mem_valid, mem_rw} !== '0) errors++;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== '0) begin
            errors++;
            $display("FAIL idle_no_req: busy=%b gnt=%b, want 0/0000", busy, gnt);
        end
    endtask

    task automatic test_round_robin;
        int order [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] exp_g;
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(12'h100 + i);
        rw = '0; mem_rdata = 8'h11; mem_ready = 1'b1; req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_g = '0;
            exp_g[order[t]] = 1'b1;
            @(negedge clk);
            checks++;
            if (gnt !== exp_g || mem_valid !== 1'b1 || mem_addr !== AW'(12'h100 + order[t])) begin
                errors++;
                $display("FAIL rr_grant%0d: gnt=%b mv=%b addr=%h, want gnt=%b mv=1 addr=%h",
                         t, gnt, mem_valid, mem_addr, exp_g, 12'h100 + order[t]);
            end
            @(negedge clk);
            checks++;
            if (done !== exp_g || gnt !== exp_g || rdata !== 8'h11 || err !== 1'b0) begin
                errors++;
                $display("FAIL rr_done%0d: done=%b gnt=%b rdata=%h err=%b, want %b %b 11 0",
                         t, done, gnt, rdata, err, exp_g, exp_g);
            end
            @(negedge clk);
            checks++;
            if (gnt !== '0 || busy !== 1'b0 || done !== '0) begin
                errors++;
                $display("FAIL rr_idle%0d: gnt=%b busy=%b done=%b, want 0000 0 0000",
                         t, gnt, busy, done);
            end
        end
        req = '0; mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap_skip;
        mem_ready = 1'b1; req = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (done !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_serve3: done=%b, want 1000", done);
        end
        req = 4'b1010;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_grant1: gnt=%b, want 0010", gnt);
        end
        @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL skip_grant3: gnt=%b, want 1000", gnt);
        end
        @(negedge clk);
        req = '0; mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read;
        int gcnt = 0;
        rw = '0; addr[1*AW +: AW] = 12'h3A5; req = 4'b0010; mem_ready = 1'b0;
        @(negedge clk);
        if (gnt === 4'b0010) gcnt++;
        checks++;
        if (mem_addr !== 12'h3A5 || mem_rw !== 1'b0 || mem_valid !== 1'b1) begin
            errors++;
            $display("FAIL read_req: addr=%h rw=%b mv=%b, want 3a5 0 1", mem_addr, mem_rw, mem_valid);
        end
        @(negedge clk);
        if (gnt === 4'b0010) gcnt++;
        @(negedge clk);
        if (gnt === 4'b0010) gcnt++;
        mem_ready = 1'b1; mem_rdata = 8'h5C;
        @(negedge clk);
        if (gnt === 4'b0010) gcnt++;
        checks++;
        if (done !== 4'b0010 || rdata !== 8'h5C || err !== 1'b0 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_done: done=%b rdata=%h err=%b mv=%b, want 0010 5c 0 0",
                     done, rdata, err, mem_valid);
        end
        req = '0; mem_ready = 1'b0; mem_rdata = 8'hEE;
        @(negedge clk);
        if (gnt === 4'b0010) gcnt++;
        checks++;
        if (gcnt != 4 || done !== '0) begin
            errors++;
            $display("FAIL read_gnt_len: gnt cycles=%0d done=%b, want 4 0000", gcnt, done);
        end
    endtask

    task automatic test_write_change;
        rw = 4'b0100; addr[2*AW +: AW] = 12'h010; wdata[2*DW +: DW] = 8'hA7;
        req = 4'b0100; mem_ready = 1'b0; mem_rdata = 8'h99;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100 || mem_addr !== 12'h010 || mem_rw !== 1'b1 || mem_wdata !== 8'hA7) begin
            errors++;
            $display("FAIL write_req: gnt=%b addr=%h rw=%b wd=%h, want 0100 010 1 a7",
                     gnt, mem_addr, mem_rw, mem_wdata);
        end
        addr[2*AW +: AW] = 12'hFFF; wdata[2*DW +: DW] = 8'h00; rw = 4'b0000;
        @(negedge clk);
        checks++;
        if (mem_addr !== 12'h010 || mem_rw !== 1'b1 || mem_wdata !== 8'hA7) begin
            errors++;
            $display("FAIL write_hold: addr=%h rw=%b wd=%h, want 010 1 a7", mem_addr, mem_rw, mem_wdata);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 4'b0100 || rdata !== 8'h00 || err !== 1'b0) begin
            errors++;
            $display("FAIL write_done: done=%b rdata=%h err=%b, want 0100 00 0", done, rdata, err);
        end
        req = '0; mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int vcnt = 0;
        req = 4'b0001; mem_ready = 1'b0; mem_rdata = 8'h77;
        for (int c = 0; c < 3 * TO; c++) begin
            @(negedge clk);
            if (done !== '0) break;
            if (mem_valid === 1'b1) vcnt++;
        end
        checks++;
        if (vcnt != TO) begin
            errors++;
            $display("FAIL timeout_len: mem_valid cycles=%0d, want %0d", vcnt, TO);
        end
        checks++;
        if (done !== 4'b0001 || err !== 1'b1 || rdata !== 8'h00 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_done: done=%b err=%b rdata=%h mv=%b, want 0001 1 00 0",
                     done, err, rdata, mem_valid);
        end
        req = 4'b0011;
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: err=%b busy=%b, want 0 0", err, busy);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL timeout_ptr: gnt=%b, want 0010", gnt);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        req = '0; mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        req = 4'b0100; mem_ready = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({gnt, done, err, busy, mem_valid, mem_rw} !== '0 || mem_addr !== '0 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_mid: gnt=%b done=%b busy=%b mv=%b addr=%h, want all 0",
                     gnt, done, busy, mem_valid, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (done !== '0 || gnt !== '0) begin
            errors++;
            $display("FAIL reset_hold: done=%b gnt=%b, want 0000 0000", done, gnt);
        end
        rst = 1'b1; req = 4'b0001;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || mem_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_regrant: gnt=%b mv=%b, want 0001 1", gnt, mem_valid);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 4'b0001) begin
            errors++;
            $display("FAIL reset_done: done=%b, want 0001", done);
        end
        req = '0; mem_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_single_read();
        test_write_change();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
